// File: rtl/jpeg_word_packer.sv
// Packs the MJPEG encoder byte stream into 128-bit DDR3 words with byte masks,
// buffers them in a show-ahead FIFO and reports the byte length of each frame.
module jpeg_word_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sof,
  input  logic             i_jpeg_valid,
  input  logic [7:0]       i_jpeg_data,
  input  logic             i_jpeg_done,
  output logic             o_word_valid,
  output logic [127:0]     o_word_data,
  output logic [15:0]      o_word_mask,
  output logic             o_word_last,
  input  logic             i_word_ready,
  output logic [LEN_W-1:0] o_frame_len,
  output logic             o_frame_len_valid,
  output logic [15:0]      o_frame_cnt,
  output logic             o_overflow,
  input  logic             i_clear
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]      DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [127:0]     asm_data;
  logic [3:0]       asm_lane;
  logic             asm_staged;
  logic [LEN_W-1:0] len_cnt;

  logic [127:0]     b_data, n_data;
  logic [3:0]       b_lane, n_lane;
  logic             b_staged, n_staged;
  logic [LEN_W-1:0] b_len, n_len;
  logic             push_a, push_b;
  logic [15:0]      mask_b;

  // sof discards the open word before any byte of this cycle is placed,
  // unless done is also present: then the old frame closes first.
  always_comb begin
    b_data   = asm_data;
    b_lane   = asm_lane;
    b_staged = asm_staged;
    b_len    = len_cnt;
    if (i_sof && !i_jpeg_done) begin
      b_data   = '0;
      b_lane   = '0;
      b_staged = 1'b0;
      b_len    = '0;
    end
    push_a   = 1'b0;
    n_data   = b_data;
    n_lane   = b_lane;
    n_staged = b_staged;
    n_len    = b_len;
    if (i_jpeg_valid) begin
      if (b_staged) begin
        push_a      = 1'b1;
        n_data      = '0;
        n_data[7:0] = i_jpeg_data;
        n_lane      = 4'd1;
        n_staged    = 1'b0;
      end else begin
        n_data[{b_lane, 3'b000} +: 8] = i_jpeg_data;
        n_staged = (b_lane == 4'd15);
        n_lane   = b_lane + 4'd1;
      end
      if (b_len != LEN_MAX) n_len = b_len + 1'b1;
    end
    push_b = i_jpeg_done && (n_staged || (n_lane != 4'd0));
    mask_b = n_staged ? 16'h0000 : (16'hFFFF << n_lane);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_data          <= '0;
      asm_lane          <= '0;
      asm_staged        <= 1'b0;
      len_cnt           <= '0;
      o_frame_len       <= '0;
      o_frame_len_valid <= 1'b0;
      o_frame_cnt       <= '0;
    end else begin
      o_frame_len_valid <= i_jpeg_done;
      if (i_jpeg_done) begin
        asm_data    <= '0;
        asm_lane    <= '0;
        asm_staged  <= 1'b0;
        len_cnt     <= '0;
        o_frame_len <= n_len;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end else begin
        asm_data   <= n_data;
        asm_lane   <= n_lane;
        asm_staged <= n_staged;
        len_cnt    <= n_len;
      end
    end
  end

  logic [127:0]  mem_data [FIFO_DEPTH];
  logic [15:0]   mem_mask [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wa_b;
  logic [CW-1:0] count;
  logic [CW:0]   free_slots;
  logic          pop, acc_a, acc_b, drop;

  // A staged word and a final word can both arrive in one cycle; each gets
  // its own slot if room remains after this cycle's pop.
  assign pop        = (count != '0) && i_word_ready;
  assign free_slots = DEPTH_C - {1'b0, count} + (CW+1)'(pop);
  assign acc_a      = push_a && (free_slots != '0);
  assign acc_b      = push_b && (free_slots > (CW+1)'(acc_a));
  assign drop       = (push_a && !acc_a) || (push_b && !acc_b);
  assign wa_b       = wr_ptr + AW'(acc_a);

  always_ff @(posedge clk) begin
    if (acc_a) begin
      mem_data[wr_ptr] <= b_data;
      mem_mask[wr_ptr] <= 16'h0000;
      mem_last[wr_ptr] <= 1'b0;
    end
    if (acc_b) begin
      mem_data[wa_b] <= n_data;
      mem_mask[wa_b] <= mask_b;
      mem_last[wa_b] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(acc_a) + CW'(acc_b) - CW'(pop);
      if (drop)         o_overflow <= 1'b1;
      else if (i_clear) o_overflow <= 1'b0;
    end
  end

  assign o_word_valid = (count != '0);
  assign o_word_data  = o_word_valid ? mem_data[rd_ptr] : '0;
  assign o_word_mask  = o_word_valid ? mem_mask[rd_ptr] : '0;
  assign o_word_last  = o_word_valid ? mem_last[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_jpeg_word_packer.sv
// Bench for jpeg_word_packer: queue-based frame/FIFO reference model checked
// every cycle, a vector table of frame sizes, and directed corner sequences.
module tb_jpeg_word_packer;
  localparam int DEPTH = 4;
  localparam int LW    = 6;
  localparam int LMAX  = (1 << LW) - 1;

  logic          clk, rst_n;
  logic          i_sof, i_jpeg_valid, i_jpeg_done, i_word_ready, i_clear;
  logic [7:0]    i_jpeg_data;
  logic          o_word_valid, o_word_last, o_frame_len_valid, o_overflow;
  logic [127:0]  o_word_data;
  logic [15:0]   o_word_mask, o_frame_cnt;
  logic [LW-1:0] o_frame_len;

  jpeg_word_packer #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .i_sof(i_sof), .i_jpeg_valid(i_jpeg_valid),
    .i_jpeg_data(i_jpeg_data), .i_jpeg_done(i_jpeg_done),
    .o_word_valid(o_word_valid), .o_word_data(o_word_data),
    .o_word_mask(o_word_mask), .o_word_last(o_word_last),
    .i_word_ready(i_word_ready), .o_frame_len(o_frame_len),
    .o_frame_len_valid(o_frame_len_valid), .o_frame_cnt(o_frame_cnt),
    .o_overflow(o_overflow), .i_clear(i_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  mask;
    logic         last;
  } word_t;

  typedef struct {
    int          n;
    bit          done_with_last;
    int          exp_words;
    logic [15:0] exp_mask;
    int          exp_len;
  } vec_t;

  word_t       mq[$];
  logic [7:0]  pend[$];
  int          mlen;
  int          exp_len;
  logic        exp_lv, exp_ovf, dropped;
  logic [15:0] exp_cnt;
  int          checks, errors;
  int          popped;
  logic [15:0] pop_mask;
  logic        pop_last, seen_lv;
  int          seen_len;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic word_t mk_word(input logic lastf);
    word_t w;
    w.data = '0;
    for (int i = 0; i < pend.size(); i++) w.data[8*i +: 8] = pend[i];
    for (int i = 0; i < 16; i++) w.mask[i] = (i >= pend.size());
    w.last = lastf;
    return w;
  endfunction

  function automatic void mpush(input word_t w);
    if (mq.size() < DEPTH) mq.push_back(w);
    else dropped = 1'b1;
  endfunction

  task automatic step();
    if (o_word_valid && i_word_ready) begin
      popped++;
      pop_mask = o_word_mask;
      pop_last = o_word_last;
    end
    dropped = 1'b0;
    if (mq.size() > 0 && i_word_ready) void'(mq.pop_front());
    if (i_sof && !i_jpeg_done) begin
      pend.delete();
      mlen = 0;
    end
    if (i_jpeg_valid) begin
      if (pend.size() == 16) begin
        mpush(mk_word(1'b0));
        pend.delete();
      end
      pend.push_back(i_jpeg_data);
      if (mlen < LMAX) mlen++;
    end
    exp_lv = 1'b0;
    if (i_jpeg_done) begin
      if (pend.size() > 0) mpush(mk_word(1'b1));
      exp_len = mlen;
      exp_lv  = 1'b1;
      exp_cnt = exp_cnt + 16'd1;
      pend.delete();
      mlen = 0;
    end
    if (dropped) exp_ovf = 1'b1;
    else if (i_clear) exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("word_valid", o_word_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("word_data", o_word_data, mq[0].data);
      check("word_mask", o_word_mask, mq[0].mask);
      check("word_last", o_word_last, mq[0].last);
    end
    check("frame_len_valid", o_frame_len_valid, exp_lv);
    if (exp_lv) check("frame_len", o_frame_len, exp_len);
    if (o_frame_len_valid) begin
      seen_lv  = 1'b1;
      seen_len = o_frame_len;
    end
    check("frame_cnt", o_frame_cnt, exp_cnt);
    check("overflow", o_overflow, exp_ovf);
  endtask

  task automatic cyc(input logic sof, input logic vld, input logic [7:0] d,
                     input logic done, input logic rdy, input logic clr);
    i_sof = sof; i_jpeg_valid = vld; i_jpeg_data = d;
    i_jpeg_done = done; i_word_ready = rdy; i_clear = clr;
    step();
  endtask

  task automatic do_reset();
    i_sof = 0; i_jpeg_valid = 0; i_jpeg_data = 0; i_jpeg_done = 0;
    i_word_ready = 0; i_clear = 0;
    rst_n = 1'b0;
    mq.delete(); pend.delete();
    mlen = 0; exp_len = 0; exp_lv = 0; exp_ovf = 0; exp_cnt = 0;
    #1;
    check("rst_outputs", {o_word_valid, o_word_data, o_word_mask, o_word_last,
          o_frame_len, o_frame_len_valid, o_frame_cnt, o_overflow}, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    checks = 0; errors = 0; popped = 0; seen_lv = 0; seen_len = 0;
    pop_mask = '0; pop_last = 0;
    tbl[0] = '{0,  1'b0, 0, 16'h0000, 0};
    tbl[1] = '{1,  1'b0, 1, 16'hFFFE, 1};
    tbl[2] = '{15, 1'b1, 1, 16'h8000, 15};
    tbl[3] = '{16, 1'b0, 1, 16'h0000, 16};
    tbl[4] = '{16, 1'b1, 1, 16'h0000, 16};
    tbl[5] = '{17, 1'b1, 2, 16'hFFFE, 17};
    tbl[6] = '{20, 1'b1, 2, 16'hFFF0, 20};
    tbl[7] = '{32, 1'b0, 2, 16'h0000, 32};
    tbl[8] = '{70, 1'b0, 5, 16'hFFC0, LMAX};

    do_reset();

    // 32 bytes then a separate done, consumer stalled
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 32; k++) cyc(0, 1, 8'(k), 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("t1_w0_lane0", o_word_data[7:0], 8'h00);
    check("t1_w0_lane15", o_word_data[127:120], 8'h0F);
    check("t1_w0_mask", o_word_mask, 16'h0000);
    check("t1_w0_last", o_word_last, 1'b0);
    check("t1_len", o_frame_len, 32);
    check("t1_cnt", o_frame_cnt, 16'd1);
    cyc(0, 0, 0, 0, 1, 0);
    check("t1_w1_lane0", o_word_data[7:0], 8'h10);
    check("t1_w1_lane15", o_word_data[127:120], 8'h1F);
    check("t1_w1_last", o_word_last, 1'b1);
    cyc(0, 0, 0, 0, 1, 0);

    // empty frame
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    check("t3_no_word", o_word_valid, 1'b0);
    check("t3_len_pulse", {o_frame_len_valid, o_frame_len}, {1'b1, 6'd0});
    check("t3_cnt", o_frame_cnt, 16'd2);

    for (int t = 0; t < 9; t++) begin
      popped = 0; seen_lv = 0; seen_len = -1;
      cyc(1, 0, 0, 0, 1, 0);
      for (int k = 0; k < tbl[t].n; k++)
        cyc(0, 1, 8'(k * 7 + t), tbl[t].done_with_last && (k == tbl[t].n - 1), 1, 0);
      if (!tbl[t].done_with_last) cyc(0, 0, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0);
      check($sformatf("tbl%0d_words", t), popped, tbl[t].exp_words);
      if (tbl[t].exp_words > 0) begin
        check($sformatf("tbl%0d_mask", t), pop_mask, tbl[t].exp_mask);
        check($sformatf("tbl%0d_last", t), pop_last, 1'b1);
      end
      check($sformatf("tbl%0d_len", t), {seen_lv, 32'(seen_len)}, {1'b1, 32'(tbl[t].exp_len)});
    end

    // overflow: five words into a four-deep FIFO
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 80; k++) cyc(0, 1, 8'(k), 0, 0, 0);
    check("t4_no_ovf_yet", o_overflow, 1'b0);
    cyc(0, 0, 0, 1, 0, 0);
    check("t4_ovf", o_overflow, 1'b1);
    popped = 0;
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 0);
    check("t4_drained", popped, 4);
    check("t4_ovf_sticky", o_overflow, 1'b1);
    cyc(0, 0, 0, 0, 1, 1);
    check("t4_clear", o_overflow, 1'b0);

    // sof in mid-frame carrying the new frame's first byte
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 8'(k + 1), 0, 0, 0);
    cyc(1, 1, 8'hAA, 0, 0, 0);
    for (int k = 0; k < 15; k++) cyc(0, 1, 8'(k + 8'h40), 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("t5_lane0", o_word_data[7:0], 8'hAA);
    check("t5_mask", o_word_mask, 16'h0000);
    check("t5_last", o_word_last, 1'b1);
    check("t5_len", o_frame_len, 16);
    cyc(0, 0, 0, 0, 1, 0);
    check("t5_single_word", o_word_valid, 1'b0);

    // full FIFO: push and pop in the same cycle
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 80; k++) cyc(0, 1, 8'(k + 3), 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      cyc(0, 1, 8'(r + 8'hC0), 0, 1, 0);
      check("t6_full_pushpop_ovf", o_overflow, 1'b0);
      for (int k = 0; k < 15; k++) cyc(0, 1, 8'(k * 5 + r), 0, 0, 0);
    end
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 0);

    // randomized traffic
    for (int c = 0; c < 500; c++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
          $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0);

    // async reset mid-frame
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 1, 8'(k), 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {o_word_valid, o_word_data, o_word_mask, o_word_last,
          o_frame_len, o_frame_len_valid, o_frame_cnt, o_overflow}, '0);
    do_reset();
    cyc(0, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
